// File: rtl/bram_burst_rd_pkg.sv
// Shared definitions for the BRAM burst read initiator: FSM states,
// default widths common with the BRAM controller, and a FIFO count-width helper.
package bram_burst_rd_pkg;

    localparam int DAT_WIDTH_DEF  = 32;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int LEN_WIDTH_DEF  = 16;
    localparam int ADDR_STEP_DEF  = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // A count must represent 0..depth inclusive, hence one bit beyond the pointer.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bram_burst_rd_if.sv
// Valid/ready word stream with a last flag; the producer uses the master modport.
interface bram_burst_rd_if #(
    parameter int DAT_WIDTH = 32
) ();
    logic [DAT_WIDTH-1:0] dat;
    logic                 val;
    logic                 rdy;
    logic                 last;

    modport master (output dat, output val, output last, input rdy);
    modport slave  (input dat, input val, input last, output rdy);
endinterface

// File: rtl/bram_burst_rd_sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two >= 2.
module bram_burst_rd_sync_fifo
    import bram_burst_rd_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign count_o  = count_q;
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign push     = wr_en_i && !full_o;
    assign pop      = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_dat_i;
    end

endmodule

// File: rtl/bram_burst_rd.sv
// Burst read initiator: issues one BRAM read per word with credit-based flow
// control so returned words always fit the output buffer.
module bram_burst_rd
    import bram_burst_rd_pkg::*;
#(
    parameter int DAT_WIDTH  = DAT_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
    parameter int ADDR_STEP  = ADDR_STEP_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] ctrl_addr_o,
    output logic                  ctrl_wren_o,
    output logic [DAT_WIDTH-1:0]  ctrl_idat_o,
    output logic                  ctrl_rden_o,
    input  logic [DAT_WIDTH-1:0]  ctrl_odat_i,
    input  logic                  ctrl_oval_i,
    bram_burst_rd_if.master       m_if
);

    localparam int CNT_W = cnt_width(FIFO_DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  inflight_q, inflight_d;
    logic                  infl_last_q, infl_last_d;
    logic                  done_q, done_d;
    logic                  issue;

    logic [DAT_WIDTH:0]    fifo_rd_dat;
    logic                  fifo_empty, fifo_full, pop, head_last;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        credit_used;

    // Buffered words plus the one possibly in flight must never exceed the FIFO.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign pop         = !fifo_empty && m_if.rdy;
    assign head_last   = fifo_rd_dat[DAT_WIDTH];

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign ctrl_addr_o = addr_q;
    assign ctrl_wren_o = 1'b0;
    assign ctrl_idat_o = '0;
    assign ctrl_rden_o = issue;

    assign m_if.val  = !fifo_empty;
    assign m_if.dat  = fifo_rd_dat[DAT_WIDTH-1:0];
    assign m_if.last = !fifo_empty && head_last;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        issue       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d = cmd_addr_i;
                    rem_d  = cmd_len_i;
                    if (cmd_len_i == '0) done_d  = 1'b1;
                    else                 state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue = (rem_q != '0) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
                if (issue) begin
                    addr_d = addr_q + ADDR_WIDTH'(ADDR_STEP);
                    rem_d  = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        inflight_d  = issue;
        infl_last_d = issue && (rem_q == LEN_WIDTH'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
        end
    end

    // Writes follow our own in-flight tracking, so a pre-reset oval is ignored.
    bram_burst_rd_sync_fifo #(
        .WIDTH (DAT_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (inflight_q),
        .wr_dat_i ({infl_last_q, ctrl_odat_i}),
        .rd_en_i  (pop),
        .rd_dat_o (fifo_rd_dat),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full),
        .count_o  (fifo_count)
    );

    a_oval_matches: assert property (@(posedge clk) disable iff (!rst_n)
        inflight_q |-> ctrl_oval_i);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        inflight_q |-> !fifo_full);

endmodule

// File: tb/tb_bram_burst_rd.sv
// Directed self-checking bench for bram_burst_rd with a scoreboard of expected
// stream words and a 1-cycle-latency memory model returning word[a] = a.
module tb_bram_burst_rd;
    import bram_burst_rd_pkg::*;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [31:0] cmdAddr = '0;
    logic [15:0] cmdLen = '0;
    logic        busy, done;
    logic [31:0] ctrlAddr;
    logic        ctrlWren, ctrlRden;
    logic [31:0] ctrlIdat;
    logic [31:0] odatQ = '0;
    logic        ovalQ = 1'b0;

    bram_burst_rd_if #(.DAT_WIDTH(32)) mIf ();

    bram_burst_rd dut (
        .clk         (clk),
        .rst_n       (rstN),
        .cmd_valid_i (cmdValid),
        .cmd_ready_o (cmdReady),
        .cmd_addr_i  (cmdAddr),
        .cmd_len_i   (cmdLen),
        .busy_o      (busy),
        .done_o      (done),
        .ctrl_addr_o (ctrlAddr),
        .ctrl_wren_o (ctrlWren),
        .ctrl_idat_o (ctrlIdat),
        .ctrl_rden_o (ctrlRden),
        .ctrl_odat_i (odatQ),
        .ctrl_oval_i (ovalQ),
        .m_if        (mIf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ovalQ <= ctrlRden;
        if (ctrlRden) odatQ <= ctrlAddr;
    end

    int          errors = 0;
    int          checks = 0;
    int          popCount = 0;
    int          lastCount = 0;
    int          rdenCount = 0;
    int          doneCount = 0;
    logic [32:0] sb [$];
    logic [31:0] issueLog [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor and event counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (rstN) begin
            if (ctrlRden) begin
                rdenCount++;
                issueLog.push_back(ctrlAddr);
            end
            if (done) doneCount++;
            if (mIf.val && mIf.rdy) begin
                logic [32:0] exp;
                popCount++;
                if (mIf.last) lastCount++;
                check("sb_has_entry", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    check("m_dat", 64'(mIf.dat), 64'(exp[31:0]));
                    check("m_last", 64'(mIf.last), 64'(exp[32]));
                end
            end
        end
    end

    task automatic applyStep(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendCmd(input logic [31:0] a, input logic [15:0] n);
        logic [31:0] wa;
        applyStep(1);
        check("cmd_ready_before_send", 64'(cmdReady), 64'd1);
        cmdValid = 1'b1;
        cmdAddr  = a;
        cmdLen   = n;
        for (int i = 0; i < int'(n); i++) begin
            wa = a + 32'(4 * i);
            sb.push_back({(i == int'(n) - 1), wa});
        end
        applyStep(1);
        cmdValid = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            applyStep(1);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] expWrap [4];
        int          savedPops;
        bit          found;
        bit          seen;

        mIf.rdy = 1'b1;
        #12;
        check("rst_cmd_ready", 64'(cmdReady), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rden", 64'(ctrlRden), 64'd0);
        check("rst_addr", 64'(ctrlAddr), 64'd0);
        check("rst_m_val", 64'(mIf.val), 64'd0);
        check("rst_m_last", 64'(mIf.last), 64'd0);
        check("rst_wren", 64'(ctrlWren), 64'd0);
        check("rst_idat", 64'(ctrlIdat), 64'd0);
        rstN = 1'b1;

        // Basic burst with exact cycle timing.
        sendCmd(32'h100, 16'd4);
        check("basic_c1_rden", 64'(ctrlRden), 64'd1);
        check("basic_c1_addr", 64'(ctrlAddr), 64'h100);
        check("basic_c1_busy", 64'(busy), 64'd1);
        applyStep(1);
        check("basic_c2_m_val", 64'(mIf.val), 64'd0);
        check("basic_c2_addr", 64'(ctrlAddr), 64'h104);
        applyStep(1);
        check("basic_c3_m_val", 64'(mIf.val), 64'd1);
        check("basic_c3_m_dat", 64'(mIf.dat), 64'h100);
        applyStep(3);
        check("basic_c6_m_last", 64'(mIf.last), 64'd1);
        check("basic_c6_m_dat", 64'(mIf.dat), 64'h10C);
        applyStep(1);
        check("basic_c7_done", 64'(done), 64'd1);
        check("basic_c7_idle", 64'(cmdReady), 64'd1);
        check("basic_c7_m_val", 64'(mIf.val), 64'd0);
        applyStep(1);
        check("basic_c8_done_low", 64'(done), 64'd0);
        check("basic_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure: only FIFO_DEPTH reads may be issued while stalled.
        mIf.rdy   = 1'b0;
        rdenCount = 0;
        popCount  = 0;
        sendCmd(32'h200, 16'd8);
        applyStep(10);
        check("bp_rden_stalled", 64'(rdenCount), 64'd4);
        check("bp_m_val", 64'(mIf.val), 64'd1);
        check("bp_head_stable", 64'(mIf.dat), 64'h200);
        mIf.rdy = 1'b1;
        waitDone(60, "bp_done");
        check("bp_rden_total", 64'(rdenCount), 64'd8);
        check("bp_pops", 64'(popCount), 64'd8);

        // Random downstream ready over a long burst.
        popCount  = 0;
        lastCount = 0;
        sendCmd(32'h1000, 16'd100);
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            applyStep(1);
            mIf.rdy = 1'($urandom_range(0, 1));
            if (done) seen = 1'b1;
        end
        check("rand_done", 64'(seen), 64'd1);
        check("rand_pops", 64'(popCount), 64'd100);
        check("rand_single_last", 64'(lastCount), 64'd1);
        mIf.rdy = 1'b1;

        // Address wrap modulo 2^32.
        issueLog.delete();
        sendCmd(32'hFFFF_FFF8, 16'd4);
        waitDone(30, "wrap_done");
        expWrap = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        check("wrap_count", 64'(issueLog.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < issueLog.size()) check("wrap_addr", 64'(issueLog[i]), 64'(expWrap[i]));
        end

        // Zero-length command.
        applyStep(2);
        rdenCount = 0;
        popCount  = 0;
        doneCount = 0;
        sendCmd(32'h300, 16'd0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        applyStep(1);
        check("zero_done_low", 64'(done), 64'd0);
        applyStep(3);
        check("zero_rden", 64'(rdenCount), 64'd0);
        check("zero_pops", 64'(popCount), 64'd0);
        check("zero_done_once", 64'(doneCount), 64'd1);
        check("zero_ready", 64'(cmdReady), 64'd1);

        // Reset during word 3 of 8, with a stale oval arriving after release.
        mIf.rdy = 1'b0;
        doneCount = 0;
        sendCmd(32'h400, 16'd8);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ctrlRden && ctrlAddr == 32'h408) begin
                found = 1'b1;
                break;
            end
            applyStep(1);
        end
        check("rst_word3_found", 64'(found), 64'd1);
        @(posedge clk);
        #1 rstN = 1'b0;
        #1;
        check("mid_rst_rden", 64'(ctrlRden), 64'd0);
        check("mid_rst_addr", 64'(ctrlAddr), 64'd0);
        check("mid_rst_m_val", 64'(mIf.val), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        sb.delete();
        #1 rstN = 1'b1;
        savedPops = popCount;
        mIf.rdy = 1'b1;
        applyStep(3);
        check("stale_not_written", 64'(mIf.val), 64'd0);
        check("stale_no_pops", 64'(popCount - savedPops), 64'd0);
        check("stale_no_done", 64'(doneCount), 64'd0);
        sendCmd(32'h500, 16'd2);
        waitDone(20, "post_rst_done");
        check("post_rst_pops", 64'(popCount - savedPops), 64'd2);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        applyStep(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
